// File: rtl/axis_derivative_pkg.sv
// Shared types and the saturation helper for the AXI-Stream derivative block.
package axis_derivative_pkg;

   typedef enum logic [0:0] {
      DIFF1 = 1'b0,
      DIFF5 = 1'b1
   } deriv_mode_e;

   localparam int unsigned MAX_DATA_W = 32;
   localparam int unsigned SAT_IN_W   = MAX_DATA_W + 3;

   typedef struct packed {
      logic                         sat;
      logic signed [MAX_DATA_W-1:0] val;
   } sat_res_t;

   // Clip a sign-extended full-precision value to a data_w-bit signed range.
   function automatic sat_res_t saturate(input logic signed [SAT_IN_W-1:0] v,
                                         input int unsigned                data_w);
      logic signed [SAT_IN_W-1:0] one;
      logic signed [SAT_IN_W-1:0] hi;
      logic signed [SAT_IN_W-1:0] lo;
      sat_res_t                   res;
      one     = SAT_IN_W'(1);
      hi      = (one <<< (data_w - 1)) - one;
      lo      = -(one <<< (data_w - 1));
      res.sat = 1'b0;
      res.val = v[MAX_DATA_W-1:0];
      if (v > hi) begin
         res.sat = 1'b1;
         res.val = hi[MAX_DATA_W-1:0];
      end else if (v < lo) begin
         res.sat = 1'b1;
         res.val = lo[MAX_DATA_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/deriv_hist_bank.sv
// Per-channel sample delay line; tap 0 is x[n-1], tap DEPTH-1 is x[n-DEPTH].
module deriv_hist_bank #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NUM_CH = 1,
   parameter int unsigned DEPTH  = 1,
   parameter int unsigned CH_W   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [CH_W-1:0]          ch,
   input  logic [DATA_W-1:0]        wr_data,
   output logic [DEPTH*DATA_W-1:0]  hist_c
);

   logic [DATA_W-1:0] hist_q [NUM_CH][DEPTH];
   logic [DATA_W-1:0] hist_d [NUM_CH][DEPTH];

   // Shift the addressed channel only; other channels hold.
   always_comb begin
      hist_d = hist_q;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (wr_en && (ch == CH_W'(c))) begin
            for (int unsigned t = DEPTH - 1; t > 0; t--) begin
               hist_d[c][t] = hist_q[c][t-1];
            end
            hist_d[c][0] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned t = 0; t < DEPTH; t++) begin
               hist_q[c][t] <= '0;
            end
         end
      end else begin
         hist_q <= hist_d;
      end
   end

   always_comb begin
      hist_c = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (ch == CH_W'(c)) begin
            for (int unsigned t = 0; t < DEPTH; t++) begin
               hist_c[t*DATA_W +: DATA_W] = hist_q[c][t];
            end
         end
      end
   end

endmodule

// File: rtl/axis_derivative.sv
// Streaming per-channel derivative (first difference or five-point) with
// saturation, a single output register and AXI-Stream handshakes.
module axis_derivative
   import axis_derivative_pkg::*;
#(
   parameter  int unsigned DATA_W = 16,
   parameter  int unsigned NUM_CH = 1,
   parameter  int unsigned MODE   = 0,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic [CH_W-1:0]   s_axis_tuser,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic [CH_W-1:0]   m_axis_tuser,
   output logic              sat_flag,
   output logic              ch_err
);

   localparam bit          IS_DIFF5 = (MODE == 32'(DIFF5));
   localparam int unsigned DEPTH    = IS_DIFF5 ? 4 : 1;
   localparam int unsigned FULL_W   = DATA_W + 3;

   logic                     m_valid_q, m_valid_d;
   logic [DATA_W-1:0]        m_data_q, m_data_d;
   logic [CH_W-1:0]          m_user_q, m_user_d;
   logic                     sat_q, sat_d;
   logic                     ch_err_q, ch_err_d;

   logic                     accept_c;
   logic                     ch_ok_c;
   logic                     wr_en_c;
   logic [DEPTH*DATA_W-1:0]  hist_c;
   logic signed [FULL_W-1:0] x_c;
   logic signed [FULL_W-1:0] full_c;
   sat_res_t                 sat_res_c;
   logic                     unused_c;

   assign s_axis_tready = !m_valid_q || m_axis_tready;
   assign accept_c      = s_axis_tvalid && s_axis_tready;
   assign ch_ok_c       = 32'(s_axis_tuser) < NUM_CH;
   assign wr_en_c       = accept_c && ch_ok_c;
   assign x_c           = FULL_W'($signed(s_axis_tdata));

   deriv_hist_bank #(
      .DATA_W (DATA_W),
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH),
      .CH_W   (CH_W)
   ) u_hist (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en_c),
      .ch      (s_axis_tuser),
      .wr_data (s_axis_tdata),
      .hist_c  (hist_c)
   );

   // Full-precision derivative; the >>> on a signed value floors toward -inf.
   if (IS_DIFF5) begin : g_diff5
      logic signed [FULL_W-1:0] h1_c, h3_c, h4_c, sum_c;
      logic                     unused_tap_c;
      assign h1_c         = FULL_W'($signed(hist_c[0        +: DATA_W]));
      assign h3_c         = FULL_W'($signed(hist_c[2*DATA_W +: DATA_W]));
      assign h4_c         = FULL_W'($signed(hist_c[3*DATA_W +: DATA_W]));
      assign sum_c        = (x_c <<< 1) + h1_c - h3_c - (h4_c <<< 1);
      assign full_c       = sum_c >>> 3;
      assign unused_tap_c = ^hist_c[DATA_W +: DATA_W];
   end else begin : g_diff1
      assign full_c = x_c - FULL_W'($signed(hist_c));
   end

   assign sat_res_c = saturate(SAT_IN_W'(full_c), DATA_W);
   assign unused_c  = ^sat_res_c;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_user_d  = m_user_q;
      sat_d     = sat_q;
      ch_err_d  = ch_err_q;
      if (m_axis_tready) begin
         m_valid_d = 1'b0;
      end
      if (wr_en_c) begin
         m_valid_d = 1'b1;
         m_data_d  = sat_res_c.val[DATA_W-1:0];
         m_user_d  = s_axis_tuser;
         sat_d     = sat_q | sat_res_c.sat;
      end
      // Out-of-range channel is swallowed: no output, no history update.
      if (accept_c && !ch_ok_c) begin
         ch_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_user_q  <= '0;
         sat_q     <= 1'b0;
         ch_err_q  <= 1'b0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_user_q  <= m_user_d;
         sat_q     <= sat_d;
         ch_err_q  <= ch_err_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tuser  = m_user_q;
   assign sat_flag      = sat_q;
   assign ch_err        = ch_err_q;

endmodule
